// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan driver: holds an 8-nibble frame buffer and cycles a
// digit select, presenting the selected nibble and its blank flag to the decoder.
module display_scan_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr_en,
  input  logic [2:0]  i_wr_addr,
  input  logic [3:0]  i_wr_data,
  input  logic        i_load_all,
  input  logic [31:0] i_frame_in,
  input  logic [7:0]  i_digit_mask,
  output logic [3:0]  o_num,
  output logic [2:0]  o_sel,
  output logic        o_blank,
  output logic        o_frame_done
);

  localparam int            PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [2:0]    SEL_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [3:0]    DIGITS     = 4'(NUM_DIGITS);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_sel;
  logic [3:0]    r_buf [8];
  logic [3:0]    r_num;
  logic          r_blank;
  logic          r_frame_done;

  logic          w_tick;
  logic          w_wrap;
  logic [2:0]    w_sel_nxt;
  logic [3:0]    w_buf_nxt [8];

  always_comb begin
    w_tick    = (r_presc == PRESC_LAST);
    w_wrap    = w_tick && (r_sel == SEL_LAST);
    w_sel_nxt = r_sel;
    if (w_wrap)
      w_sel_nxt = 3'd0;
    else if (w_tick)
      w_sel_nxt = r_sel + 3'd1;
  end

  // Post-edge buffer image; num is read from it so writes show through at once.
  always_comb begin
    for (int k = 0; k < 8; k++)
      w_buf_nxt[k] = i_load_all ? i_frame_in[4*k +: 4] : r_buf[k];
    if (!i_load_all && i_wr_en && ({1'b0, i_wr_addr} < DIGITS))
      w_buf_nxt[i_wr_addr] = i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_sel        <= 3'd0;
      for (int k = 0; k < 8; k++)
        r_buf[k] <= 4'd0;
      r_num        <= 4'd0;
      r_blank      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + PW'(1);
      r_sel        <= w_sel_nxt;
      r_buf        <= w_buf_nxt;
      r_num        <= w_buf_nxt[w_sel_nxt];
      r_blank      <= i_digit_mask[w_sel_nxt];
      r_frame_done <= w_wrap;
    end
  end

  assign o_num        = r_num;
  assign o_sel        = r_sel;
  assign o_blank      = r_blank;
  assign o_frame_done = r_frame_done;

endmodule
